// File: rtl/matmult_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matmult_pkg : shared types and helpers for the sequenced matmult engine   |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
package matmult_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_GNT = 3'd1,
    RUN      = 3'd2,
    DRAIN    = 3'd3,
    FIN      = 3'd4
  } state_t;

  // Tag address field is sized for the widest supported RAM; engines use the low ADDR_W bits.
  localparam int c_tag_aw = 16;

  typedef struct packed {
    logic                valid;
    logic                first;
    logic                last;
    logic [c_tag_aw-1:0] addr;
  } tag_t;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic logic signed [63:0] sat_s(input logic signed [63:0] acc, input int out_w);
    logic signed [63:0] lim_hi;
    logic signed [63:0] lim_lo;
    lim_hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lim_lo = -(64'sd1 <<< (out_w - 1));
    if (acc > lim_hi)      return lim_hi;
    else if (acc < lim_lo) return lim_lo;
    else                   return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matmult_mac_lane.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matmult_mac_lane : valid-tagged MAC, scale/saturate and C write register  |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module matmult_mac_lane
  import matmult_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 40,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 0,
  parameter int SAT        = 1
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     i_valid,
  input  logic                     i_first,
  input  logic                     i_last,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  input  logic                     i_clr_sat,
  output logic                     o_we,
  output logic [ADDR_W-1:0]        o_wadr,
  output logic signed [OUT_W-1:0]  o_d,
  output logic                     o_sat_flag
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_acc_next;
  logic signed [ACC_W-1:0]    w_shifted;
  logic signed [63:0]         w_sh64;
  logic signed [63:0]         w_sat64;
  logic                       w_sat_hit;
  logic signed [OUT_W-1:0]    w_out;

  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_we;
  logic [ADDR_W-1:0]          r_wadr;
  logic signed [OUT_W-1:0]    r_d;
  logic                       r_sat_flag;

  assign w_prod     = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_acc_next = i_first ? w_prod_ext : r_acc + w_prod_ext;
  assign w_shifted  = w_acc_next >>> FRAC_SHIFT;
  assign w_sh64     = 64'(w_shifted);
  assign w_sat64    = sat_s(w_sh64, OUT_W);
  assign w_sat_hit  = (SAT != 0) && (w_sat64 != w_sh64);
  assign w_out      = (SAT != 0) ? OUT_W'(w_sat64) : OUT_W'(w_shifted);

  // The write register captures the freshly accumulated sum so C lands one cycle after the last MAC.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_acc      <= '0;
      r_we       <= 1'b0;
      r_wadr     <= '0;
      r_d        <= '0;
      r_sat_flag <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (i_valid) r_acc <= w_acc_next;
      if (i_valid && i_last) begin
        r_we   <= 1'b1;
        r_wadr <= i_addr;
        r_d    <= w_out;
      end
      if (i_clr_sat)                           r_sat_flag <= 1'b0;
      else if (i_valid && i_last && w_sat_hit) r_sat_flag <= 1'b1;
    end
  end

  assign o_we       = r_we;
  assign o_wadr     = r_wadr;
  assign o_d        = r_d;
  assign o_sat_flag = r_sat_flag;

endmodule
`default_nettype wire

// File: rtl/matmult_seq_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | matmult_seq_engine : sequenced C = A x B controller over 1R1W RAM ports   |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module matmult_seq_engine
  import matmult_pkg::*;
#(
  parameter int N          = 10,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 40,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 0,
  parameter int RD_LAT     = 1,
  parameter int SAT        = 1
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_sat_flag,
  output logic                     o_a_re,
  output logic [ADDR_W-1:0]        o_a_radr,
  input  logic signed [DATA_W-1:0] i_a_q,
  input  logic                     i_a_req_vz,
  output logic                     o_a_rls_lz,
  output logic                     o_b_re,
  output logic [ADDR_W-1:0]        o_b_radr,
  input  logic signed [DATA_W-1:0] i_b_q,
  input  logic                     i_b_req_vz,
  output logic                     o_b_rls_lz,
  output logic                     o_c_we,
  output logic [ADDR_W-1:0]        o_c_wadr,
  output logic signed [OUT_W-1:0]  o_c_d,
  input  logic                     i_c_req_vz,
  output logic                     o_c_rls_lz
);

  localparam int                c_cnt_w = cnt_width(N);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N - 1);

  state_t             r_state;
  logic [c_cnt_w-1:0] r_i, r_j, r_k;
  logic               r_busy, r_done, r_re;
  logic [ADDR_W-1:0]  r_a_radr, r_b_radr;
  tag_t               r_iss;
  tag_t               r_pipe [RD_LAT];

  logic               w_grant, w_i_end, w_j_end, w_k_end, w_inflight, w_accept;
  logic [ADDR_W-1:0]  w_a_adr, w_b_adr, w_c_adr;
  logic               w_unused_tag;

  assign w_grant  = i_a_req_vz & i_b_req_vz & i_c_req_vz;
  assign w_accept = (r_state == IDLE) & i_start;
  assign w_i_end  = (r_i == c_last);
  assign w_j_end  = (r_j == c_last);
  assign w_k_end  = (r_k == c_last);
  assign w_a_adr  = ADDR_W'(r_i) * ADDR_W'(N) + ADDR_W'(r_k);
  assign w_b_adr  = ADDR_W'(r_k) * ADDR_W'(N) + ADDR_W'(r_j);
  assign w_c_adr  = ADDR_W'(r_i) * ADDR_W'(N) + ADDR_W'(r_j);

  always_comb begin
    w_inflight = r_iss.valid;
    for (int d = 0; d < RD_LAT; d++) w_inflight = w_inflight | r_pipe[d].valid;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state  <= IDLE;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_re     <= 1'b0;
      r_a_radr <= '0;
      r_b_radr <= '0;
      r_iss    <= '0;
    end else begin
      r_re   <= 1'b0;
      r_done <= 1'b0;
      r_iss  <= '0;
      case (r_state)
        IDLE: if (i_start) begin
          r_state <= WAIT_GNT;
          r_busy  <= 1'b1;
          r_i     <= '0;
          r_j     <= '0;
          r_k     <= '0;
        end
        WAIT_GNT: if (w_grant) r_state <= RUN;
        RUN: if (w_grant) begin
          // A stalled cycle leaves counters and the presented addresses untouched.
          r_re     <= 1'b1;
          r_a_radr <= w_a_adr;
          r_b_radr <= w_b_adr;
          r_iss    <= '{valid: 1'b1, first: (r_k == '0), last: w_k_end,
                        addr: c_tag_aw'(w_c_adr)};
          if (w_k_end) begin
            r_k <= '0;
            if (w_j_end) begin
              r_j <= '0;
              if (w_i_end) r_state <= DRAIN;
              else         r_i     <= r_i + 1'b1;
            end else begin
              r_j <= r_j + 1'b1;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        DRAIN: if (!w_inflight) begin
          r_state <= FIN;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Tag travels alongside the read so the MAC only consumes data that was actually requested.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int d = 0; d < RD_LAT; d++) r_pipe[d] <= '0;
    end else begin
      r_pipe[0] <= r_iss;
      for (int d = 1; d < RD_LAT; d++) r_pipe[d] <= r_pipe[d-1];
    end
  end

  assign w_unused_tag = ^r_pipe[RD_LAT-1].addr;

  matmult_mac_lane #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .ACC_W     (ACC_W),
    .OUT_W     (OUT_W),
    .FRAC_SHIFT(FRAC_SHIFT),
    .SAT       (SAT)
  ) u_lane (
    .clk       (clk),
    .arst_n    (arst_n),
    .i_valid   (r_pipe[RD_LAT-1].valid),
    .i_first   (r_pipe[RD_LAT-1].first),
    .i_last    (r_pipe[RD_LAT-1].last),
    .i_addr    (r_pipe[RD_LAT-1].addr[ADDR_W-1:0]),
    .i_a       (i_a_q),
    .i_b       (i_b_q),
    .i_clr_sat (w_accept),
    .o_we      (o_c_we),
    .o_wadr    (o_c_wadr),
    .o_d       (o_c_d),
    .o_sat_flag(o_sat_flag)
  );

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_a_re     = r_re;
  assign o_b_re     = r_re;
  assign o_a_radr   = r_a_radr;
  assign o_b_radr   = r_b_radr;
  assign o_a_rls_lz = r_done;
  assign o_b_rls_lz = r_done;
  assign o_c_rls_lz = r_done;

endmodule
`default_nettype wire
